q_max_select: RTL and testbench

Greedy action selector and max-Q reader for the maze Q-learning datapath. Given a maze state, it scans that state's four Q-table entries through a one-cycle-latency read port and returns the largest Q value and the action that holds it. The result drives both the agent's next move and the `max_Q` operand consumed by the Q-update stage. It is the read-side counterpart of the Q-update writer.

---
 rtl/q_max_select_if.sv | 25 ++
 rtl/q_max_select.sv | 131 +++++++++++++
 tb/tb_q_max_select.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/q_max_select_if.sv
// Request, result and Q-table read-port bundle for q_max_select.
// master: requester plus Q-table side; slave: the selector itself.
interface q_max_select_if;
    logic        start;
    logic [5:0]  maze_state;
    logic [5:0]  q_rd_state;
    logic [3:0]  q_rd_action;
    logic [31:0] q_rd_data;
    logic [31:0] max_Q;
    logic [3:0]  action;
    logic        done;
    logic        busy;
    logic        invalid;
    logic        explored;

    modport master (
        output start, maze_state, q_rd_data,
        input  q_rd_state, q_rd_action, max_Q, action, done, busy, invalid, explored
    );

    modport slave (
        input  start, maze_state, q_rd_data,
        output q_rd_state, q_rd_action, max_Q, action, done, busy, invalid, explored
    );
endinterface

// File: rtl/q_max_select.sv
// Greedy action selector / max-Q reader: scans a state's Q entries and returns the argmax.
// Optional epsilon-greedy exploration is enabled by defining QSEL_EXPLORE_EN.
module q_max_select #(
    parameter int unsigned NUM_STATES  = 37,
    parameter int unsigned NUM_ACTIONS = 4,
    parameter logic [7:0]  EPSILON     = 8'd26
) (
    input logic            clk,
    input logic            rst,
    q_max_select_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD, LAST, DONE} state_t;

    localparam logic [6:0] STATE_LIMIT = 7'(NUM_STATES);
    localparam logic [3:0] LAST_ACT    = 4'(NUM_ACTIONS - 1);

    state_t             state;
    logic               cap_invalid;
    logic signed [31:0] best;
    logic [3:0]         best_act;

    logic               bad_state;
    logic               word_valid;
    logic [3:0]         word_idx;
    logic               take;

    logic               explore_en;
    logic [9:0]         rnd;
    logic               explore_hit;

`ifdef QSEL_EXPLORE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign explore_en = 1'b1;
    assign rnd        = lfsr[9:0];
`else
    assign explore_en = 1'b0;
    assign rnd        = '0;
`endif

    assign explore_hit = explore_en && (rnd[7:0] < EPSILON);
    assign bad_state   = ({1'b0, bus.maze_state} >= STATE_LIMIT);

    // Read data lags the address by one cycle: in RD the returned word belongs to
    // the previous action; in LAST it belongs to the final action still on the port.
    always_comb begin
        word_valid = 1'b0;
        word_idx   = '0;
        if (state == RD && bus.q_rd_action != 4'd0) begin
            word_valid = 1'b1;
            word_idx   = 4'(bus.q_rd_action - 4'd1);
        end else if (state == LAST) begin
            word_valid = 1'b1;
            word_idx   = bus.q_rd_action;
        end
    end

    assign take = word_valid && ((word_idx == 4'd0) || ($signed(bus.q_rd_data) > best));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cap_invalid     <= 1'b0;
            best            <= '0;
            best_act        <= '0;
            bus.q_rd_state  <= '0;
            bus.q_rd_action <= '0;
            bus.max_Q       <= '0;
            bus.action      <= '0;
            bus.done        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.invalid     <= 1'b0;
            bus.explored    <= 1'b0;
        end else begin
            if (take) begin
                best     <= $signed(bus.q_rd_data);
                best_act <= word_idx;
            end

            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    bus.busy <= bus.start;
                    if (bus.start) begin
                        cap_invalid <= bad_state;
                        if (bad_state) begin
                            state <= DONE;
                        end else begin
                            bus.q_rd_state  <= bus.maze_state;
                            bus.q_rd_action <= '0;
                            state           <= RD;
                        end
                    end
                end
                RD: begin
                    if (bus.q_rd_action == LAST_ACT) begin
                        state <= LAST;
                    end else begin
                        bus.q_rd_action <= bus.q_rd_action + 4'd1;
                    end
                end
                LAST: begin
                    state <= DONE;
                end
                DONE: begin
                    bus.max_Q    <= cap_invalid ? '0 : best;
                    bus.invalid  <= cap_invalid;
                    bus.explored <= !cap_invalid && explore_hit;
                    if (cap_invalid) begin
                        bus.action <= '0;
                    end else if (explore_hit) begin
                        bus.action <= {2'b00, rnd[9:8]};
                    end else begin
                        bus.action <= best_act;
                    end
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_q_max_select.sv
// Self-checking bench for q_max_select: argmax reference model, Q-table responder, directed + random requests.
module tb_q_max_select;
    logic clk;
    logic rst;

    q_max_select_if bus();

`ifdef QSEL_EXPLORE_EN
    q_max_select #(.EPSILON(8'd255)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    q_max_select dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] q_mem [64][4];

    // Q-table with one-cycle read latency
    always @(posedge clk) bus.q_rd_data <= q_mem[bus.q_rd_state][bus.q_rd_action[1:0]];

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Reference: plain argmax over the state's four entries, first maximum wins.
    task automatic ref_scan(input logic [5:0] s, output logic [31:0] mx, output logic [3:0] a, output logic inv);
        inv = (s >= 6'd37);
        mx  = '0;
        a   = '0;
        if (!inv) begin
            mx = q_mem[s][0];
            for (int i = 1; i < 4; i++) begin
                if ($signed(q_mem[s][i]) > $signed(mx)) begin
                    mx = q_mem[s][i];
                    a  = 4'(i);
                end
            end
        end
    endtask

    logic        m_busy = 0, m_done = 0, m_inv = 0;
    logic [31:0] m_max = 0, p_max;
    logic [3:0]  m_act = 0, p_act;
    logic        p_inv;
    int          m_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_inv = 0; m_max = 0; m_act = 0; m_cnt = 0;
        end else begin
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1; m_max = p_max; m_act = p_act; m_inv = p_inv;
                end
            end else if (bus.start) begin
                ref_scan(bus.maze_state, p_max, p_act, p_inv);
                m_busy = 1;
                m_cnt  = p_inv ? 1 : 6;
            end
        end
    end

    // Compare process: every cycle, #1 after the active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
            chk("done", 32'(bus.done), 32'(m_done));
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("max_Q", bus.max_Q, m_max);
            chk("invalid", 32'(bus.invalid), 32'(m_inv));
`ifdef QSEL_EXPLORE_EN
            if (m_done) begin
                if (m_inv) chk("explored_inv", 32'(bus.explored), 32'd0);
                if (bus.explored) chk("action_range", 32'(bus.action < 4'd4), 32'd1);
                else              chk("action", 32'(bus.action), 32'(m_act));
            end
`else
            chk("action", 32'(bus.action), 32'(m_act));
            chk("explored", 32'(bus.explored), 32'd0);
`endif
        end
    end

    task automatic do_req(input logic [5:0] s, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.maze_state = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
        end
        if (!bus.done) chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic fill_table();
        logic [31:0] special [4];
        special[0] = 32'h8000_0000; special[1] = 32'hFFFF_FFFF;
        special[2] = 32'h0000_0000; special[3] = 32'h7FFF_FFFF;
        for (int s = 0; s < 64; s++)
            for (int a = 0; a < 4; a++)
                q_mem[s][a] = ($urandom_range(0, 2) == 0) ? special[$urandom_range(0, 3)] : $urandom;
    endtask

    initial begin
        int lat;
        int d0;
        fill_table();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.maze_state = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_max_Q", bus.max_Q, 32'd0);
        chk("rst_q_rd_action", 32'(bus.q_rd_action), 32'd0);
        chk("rst_q_rd_state", 32'(bus.q_rd_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Invalid state: one-cycle turnaround, read address untouched
        do_req(6'd40, lat);
        chk("inv_latency", 32'(lat), 32'd1);
        chk("inv_flag", 32'(bus.invalid), 32'd1);
        chk("inv_max_Q", bus.max_Q, 32'd0);
        chk("inv_action", 32'(bus.action), 32'd0);
        chk("inv_q_rd_action", 32'(bus.q_rd_action), 32'd0);

        // Tie between actions 1 and 2 resolves low
        q_mem[5][0] = 32'h0001_0000; q_mem[5][1] = 32'h0006_E600;
        q_mem[5][2] = 32'h0006_E600; q_mem[5][3] = 32'hFFFE_0000;
        do_req(6'd5, lat);
        chk("t1_latency", 32'(lat), 32'd6);
        chk("t1_max_Q", bus.max_Q, 32'h0006_E600);
        chk("t1_model_max", m_max, 32'h0006_E600);
        chk("t1_invalid", 32'(bus.invalid), 32'd0);
`ifndef QSEL_EXPLORE_EN
        chk("t1_action", 32'(bus.action), 32'd1);
`endif

        // Signed compare with the most negative value
        for (int a = 0; a < 3; a++) q_mem[36][a] = 32'h8000_0000;
        q_mem[36][3] = 32'hFFFF_FFFF;
        do_req(6'd36, lat);
        chk("t2_max_Q", bus.max_Q, 32'hFFFF_FFFF);
`ifndef QSEL_EXPLORE_EN
        chk("t2_action", 32'(bus.action), 32'd3);
`endif

        // Second start during RD is ignored
        q_mem[7][0] = 32'd10; q_mem[7][1] = 32'd20; q_mem[7][2] = 32'd30; q_mem[7][3] = 32'd5;
        q_mem[9][0] = 32'd100; q_mem[9][1] = 32'd1; q_mem[9][2] = 32'd1; q_mem[9][3] = 32'd1;
        d0 = n_done;
        @(negedge clk);
        bus.start = 1'b1; bus.maze_state = 6'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.maze_state = 6'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("t4_done_count", 32'(n_done - d0), 32'd1);
        chk("t4_max_Q", bus.max_Q, 32'd30);

        // Reset on the third RD cycle aborts the request
        @(negedge clk);
        bus.start = 1'b1; bus.maze_state = 6'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rst_max_Q", bus.max_Q, 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_q_rd_action", 32'(bus.q_rd_action), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        d0 = n_done;
        repeat (8) @(negedge clk);
        chk("t5_no_done", 32'(n_done - d0), 32'd0);
        do_req(6'd36, lat);
        chk("t5_after_latency", 32'(lat), 32'd6);
        chk("t5_after_max_Q", bus.max_Q, 32'hFFFF_FFFF);

        // Random requests against the model
        for (int r = 0; r < 300; r++) begin
            if (r % 50 == 0) begin
                @(negedge clk);
                fill_table();
            end
            do_req(6'($urandom_range(0, 45)), lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // start held high: back-to-back requests, 7 cycles apart
        d0 = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.maze_state = 6'd3;
        repeat (70) @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_start_done_count", 32'(n_done - d0), 32'd10);
        repeat (100) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.maze_state = 6'($urandom_range(0, 45));
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);

`ifdef QSEL_EXPLORE_EN
        begin
            int n_exp;
            logic [3:0] mask;
            n_exp = 0;
            mask = '0;
            q_mem[1][0] = 32'd0; q_mem[1][1] = 32'h0005_0000;
            q_mem[1][2] = 32'd0; q_mem[1][3] = 32'd0;
            repeat (1000) begin
                do_req(6'd1, lat);
                if (bus.explored) begin
                    n_exp++;
                    mask[bus.action[1:0]] = 1'b1;
                end
            end
            chk("explore_count", 32'(n_exp >= 980), 32'd1);
            chk("explore_cover", 32'(mask), 32'hF);
            chk("explore_max_Q", bus.max_Q, 32'h0005_0000);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
